// File: rtl/imem_loader.sv
// Boot loader: packs a framed byte stream into 32-bit imem words and verifies a trailing checksum.
// Optional inter-byte timeout is built when IMEM_LOADER_TIMEOUT_EN is defined.
module imem_loader #(
  parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
  parameter int unsigned IMEM_SIZE      = 32768,
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              IMEM_WE,
  output logic [ADDR_W-1:0] IMEM_WADDR,
  output logic [31:0]       IMEM_WDATA,
  output logic              CORE_RSTN,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR,
  output logic [ADDR_W:0]   WORDS_LOADED
);

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t            state_r, state_s;
  logic [1:0]        byte_cnt_r, byte_cnt_s;
  logic [23:0]       shift_r, shift_s;   // header bytes (shifted right) or partial data word (shifted left)
  logic [ADDR_W:0]   n_r, n_s, words_r, words_s;
  logic [7:0]        csum_r, csum_s;
  logic              we_r, we_s, core_rstn_r, core_rstn_s, done_r, done_s, err_r, err_s;
  logic [ADDR_W-1:0] waddr_r, waddr_s;
  logic [31:0]       wdata_r, wdata_s, hdr_n_s;
  logic              in_ready_s, accept_s;
  logic              unused_cfg_s;

  assign unused_cfg_s = ^{IMEM_BASE, TIMEOUT_CYCLES};
  assign in_ready_s   = (state_r == ST_HDR) || (state_r == ST_DATA) || (state_r == ST_CSUM);
  assign accept_s     = IN_VALID & in_ready_s;
  assign hdr_n_s      = {IN_DATA, shift_r};

`ifdef IMEM_LOADER_TIMEOUT_EN
  logic [31:0] to_cnt_r, to_cnt_s;
  logic        to_active_s;
  assign to_active_s = ((state_r == ST_HDR) && (byte_cnt_r != 2'd0)) ||
                       (state_r == ST_DATA) || (state_r == ST_CSUM);
`endif

  // Next-state and next-value logic for the whole loader
  always_comb begin
    state_s     = state_r;
    byte_cnt_s  = byte_cnt_r;
    shift_s     = shift_r;
    n_s         = n_r;
    words_s     = words_r;
    csum_s      = csum_r;
    we_s        = 1'b0;
    waddr_s     = waddr_r;
    wdata_s     = wdata_r;
    core_rstn_s = core_rstn_r;
    done_s      = done_r;
    err_s       = err_r;
    case (state_r)
      ST_HDR: begin
        if (!accept_s) begin
          state_s = ST_HDR;
        end else if (byte_cnt_r == 2'd3) begin
          byte_cnt_s = 2'd0;
          shift_s    = 24'd0;
          if (hdr_n_s > IMEM_SIZE) begin
            state_s = ST_ERR;
            err_s   = 1'b1;
          end else if (hdr_n_s == 32'd0) begin
            state_s = ST_CSUM;
            n_s     = '0;
          end else begin
            state_s = ST_DATA;
            n_s     = hdr_n_s[ADDR_W:0];
          end
        end else begin
          byte_cnt_s = byte_cnt_r + 2'd1;
          shift_s    = {IN_DATA, shift_r[23:8]};
        end
      end
      ST_DATA: begin
        if (!accept_s) begin
          state_s = ST_DATA;
        end else begin
          csum_s = csum_add(csum_r, IN_DATA);
          if (byte_cnt_r == 2'd3) begin
            we_s       = 1'b1;
            waddr_s    = words_r[ADDR_W-1:0];
            wdata_s    = {shift_r, IN_DATA};
            words_s    = words_r + 1'b1;
            byte_cnt_s = 2'd0;
            shift_s    = 24'd0;
            if (words_s == n_r) begin
              state_s = ST_CSUM;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            byte_cnt_s = byte_cnt_r + 2'd1;
            shift_s    = {shift_r[15:0], IN_DATA};
          end
        end
      end
      ST_CSUM: begin
        if (!accept_s) begin
          state_s = ST_CSUM;
        end else if (IN_DATA == csum_r) begin
          state_s     = ST_DONE;
          done_s      = 1'b1;
          core_rstn_s = 1'b1;
        end else begin
          state_s = ST_ERR;
          err_s   = 1'b1;
        end
      end
      ST_DONE, ST_ERR: begin
        if (START) begin
          state_s     = ST_HDR;
          byte_cnt_s  = 2'd0;
          shift_s     = 24'd0;
          n_s         = '0;
          words_s     = '0;
          csum_s      = 8'd0;
          core_rstn_s = 1'b0;
          done_s      = 1'b0;
          err_s       = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s     = ST_ERR;
        err_s       = 1'b1;
        core_rstn_s = 1'b0;
      end
    endcase
`ifdef IMEM_LOADER_TIMEOUT_EN
    // A stalled stream aborts the load; a partial word is simply dropped
    to_cnt_s = 32'd0;
    if (accept_s) begin
      to_cnt_s = 32'd0;
    end else if (to_active_s) begin
      if (to_cnt_r == 32'(TIMEOUT_CYCLES - 1)) begin
        state_s = ST_ERR;
        err_s   = 1'b1;
      end else begin
        to_cnt_s = to_cnt_r + 32'd1;
      end
    end else begin
      to_cnt_s = 32'd0;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= ST_HDR;
      byte_cnt_r  <= 2'd0;
      shift_r     <= 24'd0;
      n_r         <= '0;
      words_r     <= '0;
      csum_r      <= 8'd0;
      we_r        <= 1'b0;
      waddr_r     <= '0;
      wdata_r     <= 32'd0;
      core_rstn_r <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      byte_cnt_r  <= byte_cnt_s;
      shift_r     <= shift_s;
      n_r         <= n_s;
      words_r     <= words_s;
      csum_r      <= csum_s;
      we_r        <= we_s;
      waddr_r     <= waddr_s;
      wdata_r     <= wdata_s;
      core_rstn_r <= core_rstn_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

`ifdef IMEM_LOADER_TIMEOUT_EN
  // Inter-byte idle counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_cnt_r <= 32'd0;
    end else begin
      to_cnt_r <= to_cnt_s;
    end
  end
`endif

  assign IN_READY     = in_ready_s;
  assign IMEM_WE      = we_r;
  assign IMEM_WADDR   = waddr_r;
  assign IMEM_WDATA   = wdata_r;
  assign CORE_RSTN    = core_rstn_r;
  assign LOAD_DONE    = done_r;
  assign LOAD_ERR     = err_r;
  assign WORDS_LOADED = words_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames against a frame-level model.
module tb_imem_loader;
  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, IN_VALID = 1'b0;
  logic [7:0]  IN_DATA = 8'd0;
  logic        IN_READY, IMEM_WE, CORE_RSTN, LOAD_DONE, LOAD_ERR;
  logic [14:0] IMEM_WADDR;
  logic [31:0] IMEM_WDATA;
  logic [15:0] WORDS_LOADED;
  int total = 0, bad = 0;
  logic [14:0] wa_q[$];
  logic [31:0] wd_q[$];

  imem_loader #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .IMEM_WE(IMEM_WE), .IMEM_WADDR(IMEM_WADDR), .IMEM_WDATA(IMEM_WDATA),
    .CORE_RSTN(CORE_RSTN), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR), .WORDS_LOADED(WORDS_LOADED)
  );

  always #5 CLK = ~CLK;

  // Write monitor: one entry per cycle the strobe is high
  always @(negedge CLK) begin
    if (IMEM_WE === 1'b1) begin
      wa_q.push_back(IMEM_WADDR);
      wd_q.push_back(IMEM_WDATA);
    end
  end

  // Frame-level reference: header count, MSB-first words, checksum over data bytes
  function automatic void model(input bq_t f, output wq_t ew, output bit edone, output bit eerr);
    int unsigned n;
    logic [7:0] s;
    ew = {}; edone = 1'b0; eerr = 1'b0; s = 8'd0;
    n = {f[3], f[2], f[1], f[0]};
    if (n > 32768) begin
      eerr = 1'b1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      ew.push_back({f[4+4*i], f[5+4*i], f[6+4*i], f[7+4*i]});
      for (int j = 0; j < 4; j++) s = s + f[4+4*i+j];
    end
    if (f[4+4*n] == s) edone = 1'b1;
    else eerr = 1'b1;
  endfunction

  function automatic bq_t rand_frame(input int n, input bit good);
    bq_t f;
    logic [7:0] s = 8'd0, b;
    f = {8'(n), 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      s = s + b;
      f.push_back(b);
    end
    f.push_back(good ? s : s + 8'($urandom_range(1, 255)));
    return f;
  endfunction

  function automatic bq_t nominal_frame(input logic [7:0] csum);
    bq_t f;
    f = {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00, csum};
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge CLK);
    IN_DATA = b;
    IN_VALID = 1'b1;
    while (IN_READY !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (IN_READY !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_byte_ready: IN_READY=%b required 1", IN_READY);
      IN_VALID = 1'b0;
    end else begin
      @(posedge CLK);
      #1 IN_VALID = 1'b0;
    end
  endtask

  task automatic send_frame(input bq_t f, input int gap);
    foreach (f[i]) begin
      send_byte(f[i]);
      if (i != f.size() - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge CLK);
          IN_DATA = 8'($urandom);
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({IN_READY, IMEM_WE, IMEM_WADDR, IMEM_WDATA, CORE_RSTN, LOAD_DONE, LOAD_ERR, WORDS_LOADED} !==
        {1'b1, 1'b0, 15'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL reset_values: rdy=%b we=%b wa=%h wd=%h rstn=%b done=%b err=%b wl=%0d required 1 0 0 0 0 0 0 0",
               IN_READY, IMEM_WE, IMEM_WADDR, IMEM_WDATA, CORE_RSTN, LOAD_DONE, LOAD_ERR, WORDS_LOADED);
    end
  endtask

  task automatic test_nominal();
    bq_t f; wq_t ew; bit ed, ee;
    f = nominal_frame(8'hC0);
    model(f, ew, ed, ee);
    wa_q = {}; wd_q = {};
    send_frame(f, 0);
    @(negedge CLK);
    total++;
    if (wd_q.size() != 2 || wd_q[0] !== 32'h13050000 || wd_q[1] !== 32'h93051000 || wa_q[0] !== 15'd0 || wa_q[1] !== 15'd1) begin
      bad++;
      $display("FAIL nominal_writes: got %0d writes (first %h) required 2 writes 13050000,93051000 at 0,1", wd_q.size(), wd_q.size() > 0 ? wd_q[0] : 32'h0);
    end
    total++;
    if ({LOAD_DONE, LOAD_ERR, CORE_RSTN, IN_READY, WORDS_LOADED} !== {ed, ee, 1'b1, 1'b0, 16'd2}) begin
      bad++;
      $display("FAIL nominal_done: done=%b err=%b rstn=%b rdy=%b wl=%0d required 1 0 1 0 2", LOAD_DONE, LOAD_ERR, CORE_RSTN, IN_READY, WORDS_LOADED);
    end
  endtask

  task automatic test_bad_csum();
    bq_t f; wq_t ew; bit ed, ee;
    pulse_start();
    total++;
    if ({LOAD_DONE, CORE_RSTN, WORDS_LOADED, IN_READY} !== {1'b0, 1'b0, 16'd0, 1'b1}) begin
      bad++;
      $display("FAIL start_clear: done=%b rstn=%b wl=%0d rdy=%b required 0 0 0 1", LOAD_DONE, CORE_RSTN, WORDS_LOADED, IN_READY);
    end
    f = nominal_frame(8'hC1);
    model(f, ew, ed, ee);
    wa_q = {}; wd_q = {};
    send_frame(f, 0);
    repeat (5) @(negedge CLK);
    total++;
    if (wd_q.size() != ew.size()) begin
      bad++;
      $display("FAIL badcsum_wcount: got %0d required %0d", wd_q.size(), ew.size());
    end
    total++;
    if ({LOAD_ERR, LOAD_DONE, CORE_RSTN, IN_READY} !== {ee, ed, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL badcsum_err: err=%b done=%b rstn=%b rdy=%b required 1 0 0 0", LOAD_ERR, LOAD_DONE, CORE_RSTN, IN_READY);
    end
  endtask

  task automatic test_gaps();
    bq_t f; wq_t ew; bit ed, ee;
    pulse_start();
    f = nominal_frame(8'hC0);
    model(f, ew, ed, ee);
    wa_q = {}; wd_q = {};
    send_frame(f, 3);
    @(negedge CLK);
    total++;
    if (wd_q.size() != ew.size()) begin
      bad++;
      $display("FAIL gaps_wcount: got %0d required %0d", wd_q.size(), ew.size());
    end
    for (int i = 0; i < ew.size() && i < wd_q.size(); i++) begin
      total++;
      if (wa_q[i] !== 15'(i) || wd_q[i] !== ew[i]) begin
        bad++;
        $display("FAIL gaps_write%0d: got %h@%0d required %h@%0d", i, wd_q[i], wa_q[i], ew[i], i);
      end
    end
    total++;
    if ({LOAD_DONE, LOAD_ERR, CORE_RSTN} !== {ed, ee, 1'b1}) begin
      bad++;
      $display("FAIL gaps_done: done=%b err=%b rstn=%b required 1 0 1", LOAD_DONE, LOAD_ERR, CORE_RSTN);
    end
  endtask

  task automatic test_oversize();
    pulse_start();
    wa_q = {}; wd_q = {};
    send_frame({8'h01, 8'h80, 8'h00, 8'h00}, 0);
    @(negedge CLK);
    IN_VALID = 1'b1;
    repeat (10) @(negedge CLK);
    IN_VALID = 1'b0;
    total++;
    if ({LOAD_ERR, LOAD_DONE, IN_READY, CORE_RSTN} !== 4'b1000 || wd_q.size() != 0) begin
      bad++;
      $display("FAIL oversize: err=%b done=%b rdy=%b rstn=%b writes=%0d required 1 0 0 0 writes=0", LOAD_ERR, LOAD_DONE, IN_READY, CORE_RSTN, wd_q.size());
    end
  endtask

  task automatic test_empty();
    pulse_start();
    wa_q = {}; wd_q = {};
    send_frame({8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
    @(negedge CLK);
    total++;
    if ({LOAD_DONE, LOAD_ERR, CORE_RSTN, WORDS_LOADED} !== {1'b1, 1'b0, 1'b1, 16'd0} || wd_q.size() != 0) begin
      bad++;
      $display("FAIL empty: done=%b err=%b rstn=%b wl=%0d writes=%0d required 1 0 1 0 0", LOAD_DONE, LOAD_ERR, CORE_RSTN, WORDS_LOADED, wd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bq_t f, p; wq_t ew; bit ed, ee;
    pulse_start();
    f = nominal_frame(8'hC0);
    p = f[0:9];
    send_frame(p, 0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    total++;
    if ({IN_READY, IMEM_WE, IMEM_WADDR, IMEM_WDATA, CORE_RSTN, LOAD_DONE, LOAD_ERR, WORDS_LOADED} !==
        {1'b1, 1'b0, 15'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL midreset_values: rdy=%b we=%b wa=%h wd=%h rstn=%b wl=%0d required 1 0 0 0 0 0", IN_READY, IMEM_WE, IMEM_WADDR, IMEM_WDATA, CORE_RSTN, WORDS_LOADED);
    end
    @(negedge CLK);
    RST = 1'b0;
    model(f, ew, ed, ee);
    wa_q = {}; wd_q = {};
    send_frame(f, 0);
    @(negedge CLK);
    total++;
    if (wd_q.size() != 2 || wa_q[0] !== 15'd0 || wd_q[0] !== ew[0] || wa_q[1] !== 15'd1 || wd_q[1] !== ew[1] || LOAD_DONE !== 1'b1) begin
      bad++;
      $display("FAIL midreset_reload: writes=%0d done=%b required 2 writes from 0, done=1", wd_q.size(), LOAD_DONE);
    end
  endtask

  task automatic test_random();
    bq_t f; wq_t ew; bit ed, ee; int n;
    for (int it = 0; it < 6; it++) begin
      pulse_start();
      n = $urandom_range(1, 5);
      f = rand_frame(n, 1'($urandom_range(0, 1)));
      model(f, ew, ed, ee);
      wa_q = {}; wd_q = {};
      send_frame(f, $urandom_range(0, 2));
      @(negedge CLK);
      total++;
      if (wd_q.size() != ew.size()) begin
        bad++;
        $display("FAIL rand%0d_wcount: got %0d required %0d", it, wd_q.size(), ew.size());
      end
      for (int i = 0; i < ew.size() && i < wd_q.size(); i++) begin
        total++;
        if (wa_q[i] !== 15'(i) || wd_q[i] !== ew[i]) begin
          bad++;
          $display("FAIL rand%0d_write%0d: got %h@%0d required %h@%0d", it, i, wd_q[i], wa_q[i], ew[i], i);
        end
      end
      total++;
      if ({LOAD_DONE, LOAD_ERR, CORE_RSTN, IN_READY, WORDS_LOADED} !== {ed, ee, ed, 1'b0, 16'(n)}) begin
        bad++;
        $display("FAIL rand%0d_status: done=%b err=%b rstn=%b rdy=%b wl=%0d required %b %b %b 0 %0d",
                 it, LOAD_DONE, LOAD_ERR, CORE_RSTN, IN_READY, WORDS_LOADED, ed, ee, ed, n);
      end
    end
  endtask

`ifdef IMEM_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    pulse_start();
    wa_q = {}; wd_q = {};
    send_frame({8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05}, 0);
    repeat (15) @(posedge CLK);
    #1;
    total++;
    if (LOAD_ERR !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: LOAD_ERR=%b after 15 idle cycles required 0", LOAD_ERR);
    end
    @(posedge CLK);
    #1;
    total++;
    if (LOAD_ERR !== 1'b1 || IN_READY !== 1'b0 || wd_q.size() != 0) begin
      bad++;
      $display("FAIL timeout_fire: err=%b rdy=%b writes=%0d required 1 0 0", LOAD_ERR, IN_READY, wd_q.size());
    end
    pulse_start();
    repeat (100) @(negedge CLK);
    total++;
    if (LOAD_ERR !== 1'b0 || IN_READY !== 1'b1) begin
      bad++;
      $display("FAIL timeout_idle_hdr: err=%b rdy=%b required 0 1", LOAD_ERR, IN_READY);
    end
  endtask
`else
  task automatic test_stall();
    bq_t f; wq_t ew; bit ed, ee;
    pulse_start();
    f = rand_frame(1, 1'b1);
    model(f, ew, ed, ee);
    wa_q = {}; wd_q = {};
    send_frame(f[0:5], 0);
    repeat (60) @(negedge CLK);
    total++;
    if (LOAD_ERR !== 1'b0 || IN_READY !== 1'b1 || wd_q.size() != 0) begin
      bad++;
      $display("FAIL stall_hold: err=%b rdy=%b writes=%0d required 0 1 0", LOAD_ERR, IN_READY, wd_q.size());
    end
    send_frame(f[6:8], 0);
    @(negedge CLK);
    total++;
    if (wd_q.size() != 1 || wd_q[0] !== ew[0] || LOAD_DONE !== 1'b1) begin
      bad++;
      $display("FAIL stall_resume: writes=%0d done=%b required 1 write %h, done=1", wd_q.size(), LOAD_DONE, ew[0]);
    end
  endtask
`endif

  initial begin
    repeat (2) @(negedge CLK);
    test_reset();
    RST = 1'b0;
    test_nominal();
    test_bad_csum();
    test_gaps();
    test_oversize();
    test_empty();
    test_reset_mid();
    test_random();
`ifdef IMEM_LOADER_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
